// File: rtl/uart_pkg.sv
// Shared UART link definitions for the sensor-array transmitter and receiver.
// Holds FSM state encodings, the frame marker and the baud divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP,
    B_WAIT_HIGH
  } byte_state_t;

  typedef enum logic [1:0] {
    F_HUNT,
    F_DATA,
    F_MARK
  } frame_state_t;

  localparam logic [7:0] NEW_FRAME_ID = 8'h00;

  function automatic int baud_max(
    input int clock_rate,
    input int baud_rate
  );
    return clock_rate / baud_rate;
  endfunction

endpackage

// File: rtl/uart_receive.sv
// 8N1 byte receiver: 2-FF synchroniser plus a bit-timing byte FSM.
// Emits a one-cycle byte_valid or stop_err at the stop-bit sample.
module uart_receive
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 65_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rx_in,
  input  logic       rx_active,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       stop_err
);

  localparam int BM = baud_max(CLOCK_RATE, BAUD_RATE);
  localparam int CW = $clog2(BM) + 1;
  localparam logic [CW-1:0] HALF_END = CW'(BM / 2 - 1);
  localparam logic [CW-1:0] FULL_END = CW'(BM - 1);

  logic          rx_m;
  logic          rx_s;
  byte_state_t   state;
  byte_state_t   state_nx;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          half_hit;
  logic          full_hit;
  logic          cnt_clr;

  // Line is idle-high, so the synchroniser resets to 1.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_in;
      rx_s <= rx_m;
    end
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= B_IDLE;
    else         state <= state_nx;
  end

  // Next-state: start detect, mid-bit sampling, stop check.
  always_comb begin
    state_nx = state;
    if (!rx_active) begin
      state_nx = B_IDLE;
    end else begin
      unique case (state)
        B_IDLE:
          if (!rx_s) state_nx = B_START;
        B_START:
          if (half_hit) state_nx = rx_s ? B_IDLE : B_DATA;
        B_DATA:
          if (full_hit && bit_idx == 3'd7) state_nx = B_STOP;
        B_STOP:
          if (full_hit) state_nx = rx_s ? B_IDLE : B_WAIT_HIGH;
        B_WAIT_HIGH:
          if (rx_s) state_nx = B_IDLE;
        default:
          state_nx = B_IDLE;
      endcase
    end
  end

  // Sample-point decode; counter restarts on every state change.
  always_comb begin
    half_hit = (cnt == HALF_END);
    full_hit = (cnt == FULL_END);
    cnt_clr  = (state_nx != state)
            || (state == B_IDLE)
            || (state == B_WAIT_HIGH)
            || (state == B_DATA && full_hit);
  end

  // Baud counter, bit index and LSB-first shift register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + CW'(1);
      if (state != B_DATA) begin
        bit_idx <= '0;
      end else if (full_hit) begin
        bit_idx <= bit_idx + 3'd1;
        shift   <= {rx_s, shift[7:1]};
      end
    end
  end

  // Registered completion pulses at the stop-bit sample.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      byte_valid <= rx_active && state == B_STOP
                 && full_hit && rx_s;
      stop_err   <= rx_active && state == B_STOP
                 && full_hit && !rx_s;
    end
  end

  assign byte_data = shift;

endmodule

// File: rtl/uart_frame_rx.sv
// Sensor frame receiver: locks on the 0x00 marker and writes each
// following byte into the frame buffer at its linear pixel address.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int SW_WIRE_CNT = 16,
  parameter int RD_WIRE_CNT = 16,
  parameter int CLOCK_RATE  = 65_000_000,
  parameter int BAUD_RATE   = 115_200
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rx_in,
  input  logic rx_active,
  output logic wr_en,
  output logic [$clog2(SW_WIRE_CNT*RD_WIRE_CNT)-1:0] wr_addr,
  output logic [7:0] wr_data,
  output logic frame_done,
  output logic frame_err,
  output logic synced
);

  localparam int N  = SW_WIRE_CNT * RD_WIRE_CNT;
  localparam int AW = $clog2(N);

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          stop_err;
  frame_state_t  fstate;
  frame_state_t  fstate_nx;
  logic [AW-1:0] idx;
  logic          last;
  logic          wr_fire;
  logic          done_fire;
  logic          err_fire;

  uart_receive #(
    .CLOCK_RATE (CLOCK_RATE),
    .BAUD_RATE  (BAUD_RATE)
  ) u_rx (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rx_in      (rx_in),
    .rx_active  (rx_active),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .stop_err   (stop_err)
  );

  // Frame state register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) fstate <= F_HUNT;
    else         fstate <= fstate_nx;
  end

  // Marker hunt, data fill, then positional marker check.
  always_comb begin
    fstate_nx = fstate;
    if (!rx_active || stop_err) begin
      fstate_nx = F_HUNT;
    end else if (byte_valid) begin
      unique case (fstate)
        F_HUNT:
          if (byte_data == NEW_FRAME_ID) fstate_nx = F_DATA;
        F_DATA:
          if (last) fstate_nx = F_MARK;
        F_MARK:
          fstate_nx = (byte_data == NEW_FRAME_ID) ? F_DATA : F_HUNT;
        default:
          fstate_nx = F_HUNT;
      endcase
    end
  end

  // Write, end-of-frame and error strobes for this cycle.
  always_comb begin
    last      = (idx == AW'(N - 1));
    wr_fire   = rx_active && byte_valid && fstate == F_DATA;
    done_fire = wr_fire && last;
    err_fire  = rx_active
             && (stop_err
             || (byte_valid && fstate == F_MARK
             && byte_data != NEW_FRAME_ID));
  end

  // Pixel index wraps at N; cleared whenever a frame (re)starts.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      idx <= '0;
    end else if (fstate_nx != F_DATA) begin
      idx <= '0;
    end else if (wr_fire) begin
      idx <= last ? '0 : idx + AW'(1);
    end
  end

  // Registered buffer port; address and data hold between writes.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      synced     <= 1'b0;
    end else begin
      wr_en      <= wr_fire;
      frame_done <= done_fire;
      frame_err  <= err_fire;
      synced     <= (fstate_nx != F_HUNT);
      if (wr_fire) begin
        wr_addr <= idx;
        wr_data <= byte_data;
      end
    end
  end

endmodule
